lenet_scheduler: RTL and testbench
==================================

LENET_SCHEDULER -- requirements
Module: lenet_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning max cycles from go pulse to inference completion.
REQ-002 SHALL have parameter GAP_CYCLES, default 16, meaning idle cycles enforced between inferences (minimum 1).
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the inference counter.
REQ-004 clk  in  1  single clock, lenet clock domain; all logic rising-edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 enable  in  1  level; 1 = schedule inferences, 0 = drain and idle.
REQ-007 data_ready  in  1  one-cycle pulse, clk-synchronous; new lenet input frame stored.
REQ-008 lenet_ready  in  1  lenet status; 1 = idle/result valid, 0 = computing.
REQ-009 lenet_digit  in  4  lenet result; valid while lenet_ready=1 after a run.
REQ-010 lenet_go  out  1  one-cycle start pulse to lenet.
REQ-011 digit  out  4  last completed result, registered.
REQ-012 digit_valid  out  1  one-cycle pulse when digit updates.
REQ-013 busy  out  1  1 in any state other than IDLE and ARM.
REQ-014 timeout_err  out  1  sticky; inference exceeded TIMEOUT_CYCLES.
REQ-015 overrun  out  1  sticky; data_ready arrived while a frame was already pending.
REQ-016 infer_count  out  CNT_W  completed inferences, wraps at 2^CNT_W.

Function
REQ-017 FSM states SHALL be IDLE, ARM, GO, WAIT_LOW, WAIT_HIGH, GAP.
REQ-018 IDLE: pending cleared; enable=1 -> ARM next cycle.
REQ-019 ARM: (pending=1 or data_ready=1) -> GO; else enable=0 -> IDLE.
REQ-020 GO: lenet_go=1 for exactly this cycle; pending cleared; timeout counter loaded 0; -> WAIT_LOW.
REQ-021 WAIT_LOW: lenet_ready=0 -> WAIT_HIGH; counter increments every cycle.
REQ-022 WAIT_HIGH: lenet_ready=1 -> latch digit<=lenet_digit, digit_valid=1 next cycle, infer_count+1, -> GAP.
REQ-023 Timeout: counter reaching TIMEOUT_CYCLES-1 in WAIT_LOW or WAIT_HIGH SHALL set timeout_err, leave digit/infer_count unchanged, -> GAP.
REQ-024 GAP: hold GAP_CYCLES cycles, then -> ARM if enable=1, else IDLE.
REQ-025 data_ready outside ARM with enable=1 SHALL set pending; if pending already 1, set overrun and keep pending=1 (one-deep).
REQ-026 data_ready in IDLE, or with enable=0, SHALL be ignored (no pending, no overrun).
REQ-027 data_ready in ARM same cycle as pending=1 SHALL consume one and set overrun.
REQ-028 enable falling mid-run SHALL NOT abort; current inference completes, GAP runs, then IDLE.
REQ-029 Latency: data_ready in ARM -> lenet_go exactly 1 cycle later.
REQ-030 lenet_go SHALL never assert outside GO; at most one go per GAP window.
REQ-031 timeout_err and overrun SHALL clear only on rst.

Reset
REQ-032 rst=1 SHALL force state IDLE, lenet_go=0, digit=0, digit_valid=0, timeout_err=0, overrun=0, infer_count=0, pending=0, counters=0.
REQ-033 rst mid-inference SHALL abandon run immediately; no digit_valid generated for it.

Structure
REQ-034 FSM state enum and default TIMEOUT_CYCLES/GAP_CYCLES constants SHALL live in shared package lenet_pkg.
REQ-035 Timeout/gap counting SHALL be one sub-module, sched_timer (load, enable, terminal-count output), reused for both.
REQ-036 All outputs SHALL be registered.

Verification
REQ-037 enable=1, data_ready pulse in ARM, lenet_ready 1->0 after 3 cycles, 0->1 after 50, digit=7 -> go 1 cycle after pulse, digit=7, digit_valid one pulse, infer_count=1.
REQ-038 Two data_ready pulses during WAIT_HIGH -> overrun=1, exactly one further go after GAP (16 cycles).
REQ-039 TIMEOUT_CYCLES=100, lenet_ready held 1 after go -> timeout_err=1 at 100 cycles, infer_count=0, digit unchanged, GAP then ARM.
REQ-040 enable dropped in WAIT_HIGH -> run completes, digit_valid pulses, FSM reaches IDLE after GAP, later data_ready ignored.
REQ-041 rst asserted in WAIT_LOW -> next cycle all outputs reset values, no digit_valid, no go.
REQ-042 CNT_W=4, 17 completed runs -> infer_count=1 (wrap).

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared scheduler state encoding, default timing constants and a width helper.
// Latency: none, declarations only.
// Backpressure: not applicable.
package lenet_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        GO        = 3'd2,
        WAIT_LOW  = 3'd3,
        WAIT_HIGH = 3'd4,
        GAP       = 3'd5
    } sched_state_t;

    localparam int DEF_TIMEOUT_CYCLES = 1000000;
    localparam int DEF_GAP_CYCLES     = 16;
    localparam int DEF_CNT_W          = 16;

    // Bits needed for a counter that must reach (max(a, b) - 1).
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sched_timer.sv
// Cycle counter shared by the run-timeout and the inter-run gap phases.
// Latency: load/en act on the next edge; tc is a compare on the registered count.
// Backpressure: none; load wins over en, and the count wraps if left enabled past term.
module sched_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] cnt;

    // restart from zero on load, otherwise advance while enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/lenet_scheduler.sv
// Schedules LeNet inferences: one go per stored frame, watchdog on each run, enforced idle gap.
// Latency: data_ready seen in ARM -> lenet_go on the next cycle; result registered one cycle after lenet_ready.
// Backpressure: one frame may wait while busy; a further frame overwrites it and raises sticky overrun.
module lenet_scheduler
    import lenet_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             data_ready,
    input  logic             lenet_ready,
    input  logic [3:0]       lenet_digit,
    output logic             lenet_go,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             busy,
    output logic             timeout_err,
    output logic             overrun,
    output logic [CNT_W-1:0] infer_count
);

    // A gap of zero would let two gos land back to back, so clamp it to one cycle.
    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int TMR_W   = timer_width(TIMEOUT_CYCLES, GAP_EFF);
    localparam logic [TMR_W-1:0] TO_TERM  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_TERM = TMR_W'(GAP_EFF - 1);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic             pending;
    logic             frame_in;
    logic             tmr_load;
    logic             tmr_en;
    logic [TMR_W-1:0] tmr_term;
    logic             tmr_tc;
    logic             run_done;
    logic             run_tout;

    // Frames only count while scheduling is enabled.
    assign frame_in = data_ready & enable;

    // One timer serves both phases: it is zeroed on entry to GO (so its value is
    // cycles since the go pulse) and again on entry to GAP.
    sched_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .en   (tmr_en),
        .term (tmr_term),
        .tc   (tmr_tc)
    );

    // next-state, timer control and run-completion decode
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        tmr_term  = (state == GAP) ? GAP_TERM : TO_TERM;
        run_done  = 1'b0;
        run_tout  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (pending || frame_in) begin
                    state_nxt = GO;
                    tmr_load  = 1'b1;
                end else if (!enable) begin
                    state_nxt = IDLE;
                end
            end
            GO: begin
                tmr_en    = 1'b1;
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    run_tout  = 1'b1;
                    tmr_load  = 1'b1;
                    state_nxt = GAP;
                end else if (!lenet_ready) begin
                    state_nxt = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                tmr_en = 1'b1;
                // A result arriving on the last allowed cycle still counts.
                if (lenet_ready) begin
                    run_done  = 1'b1;
                    tmr_load  = 1'b1;
                    state_nxt = GAP;
                end else if (tmr_tc) begin
                    run_tout  = 1'b1;
                    tmr_load  = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    state_nxt = enable ? ARM : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // state register; control outputs are decoded from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lenet_go    <= 1'b0;
            busy        <= 1'b0;
            digit_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            lenet_go    <= (state_nxt == GO);
            busy        <= (state_nxt != IDLE) && (state_nxt != ARM);
            digit_valid <= run_done;
        end
    end

    // result capture, completed-run count and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            digit       <= 4'd0;
            infer_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (run_done) begin
                digit       <= lenet_digit;
                infer_count <= infer_count + CNT_W'(1);
            end
            if (run_tout) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // one-deep frame slot: consumed when leaving ARM, overflow is flagged and sticky
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pending <= 1'b0;
                end
                ARM: begin
                    if (state_nxt == GO) begin
                        pending <= 1'b0;
                        if (pending && frame_in) begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (frame_in) begin
                        if (pending) begin
                            overrun <= 1'b1;
                        end
                        pending <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lenet_scheduler.sv
// Bench for lenet_scheduler: emulated LeNet core, timestamp-based reference model, directed and random runs.
// Latency: outputs are checked every cycle against the model's prediction.
// Backpressure: not applicable.
module tb_lenet_scheduler;

    localparam int TO  = 100;
    localparam int GAP = 16;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          data_ready;
    logic          lenet_ready;
    logic [3:0]    lenet_digit;
    logic          lenet_go;
    logic [3:0]    digit;
    logic          digit_valid;
    logic          busy;
    logic          timeout_err;
    logic          overrun;
    logic [CW-1:0] infer_count;

    lenet_scheduler #(
        .TIMEOUT_CYCLES (TO),
        .GAP_CYCLES     (GAP),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .data_ready  (data_ready),
        .lenet_ready (lenet_ready),
        .lenet_digit (lenet_digit),
        .lenet_go    (lenet_go),
        .digit       (digit),
        .digit_valid (digit_valid),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overrun     (overrun),
        .infer_count (infer_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // event history taken from DUT outputs
    int go_cnt = 0;
    int dv_cnt = 0;
    int go_cyc = -1;
    int dv_cyc = -1;
    int to_cyc = -1;

    // emulated LeNet core: drops ready emu_low cycles after go, raises it emu_high cycles after go
    int         emu_go_at = -1000;
    int         emu_low   = 3;
    int         emu_high  = 50;
    bit         emu_stuck_hi = 1'b0;
    bit         emu_stuck_lo = 1'b0;
    bit         emu_rand     = 1'b0;
    logic [3:0] emu_digit    = 4'd0;

    // reference model: scheduler described by timestamps (go time, end of gap) and a frame slot
    bit         m_active;
    bit         m_in_run;
    bit         m_low_seen;
    bit         m_pending;
    int         m_go_at;
    int         m_gap_end;
    bit         e_go;
    bit         e_dv;
    bit         e_busy;
    bit         e_to;
    bit         e_ovr;
    logic [3:0] e_digit;
    int         e_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active   = 1'b0;
        m_in_run   = 1'b0;
        m_low_seen = 1'b0;
        m_pending  = 1'b0;
        m_go_at    = -1000;
        m_gap_end  = 0;
        e_go       = 1'b0;
        e_dv       = 1'b0;
        e_busy     = 1'b0;
        e_to       = 1'b0;
        e_ovr      = 1'b0;
        e_digit    = 4'd0;
        e_cnt      = 0;
    endtask

    // Predict the outputs visible in cycle n+1 from the inputs applied in cycle n.
    task automatic model_step();
        int n;
        bit frame;
        n     = cyc;
        frame = data_ready && enable;
        e_go  = 1'b0;
        e_dv  = 1'b0;
        if (!m_active) begin
            m_pending = 1'b0;
            if (enable) begin
                m_active  = 1'b1;
                m_gap_end = n + 1;
            end
        end else if (m_in_run) begin
            if (frame) begin
                if (m_pending) e_ovr = 1'b1;
                m_pending = 1'b1;
            end
            if (n > m_go_at) begin
                if (m_low_seen && lenet_ready) begin
                    e_digit   = lenet_digit;
                    e_dv      = 1'b1;
                    e_cnt     = (e_cnt + 1) % (1 << CW);
                    m_in_run  = 1'b0;
                    m_gap_end = n + 1 + GAP;
                end else if (n - m_go_at == TO - 1) begin
                    e_to      = 1'b1;
                    m_in_run  = 1'b0;
                    m_gap_end = n + 1 + GAP;
                end else if (!lenet_ready) begin
                    m_low_seen = 1'b1;
                end
            end
        end else if (n < m_gap_end) begin
            if (frame) begin
                if (m_pending) e_ovr = 1'b1;
                m_pending = 1'b1;
            end
            if (n == m_gap_end - 1 && !enable) m_active = 1'b0;
        end else begin
            if (m_pending || frame) begin
                if (m_pending && frame) e_ovr = 1'b1;
                m_pending  = 1'b0;
                m_in_run   = 1'b1;
                m_low_seen = 1'b0;
                m_go_at    = n + 1;
                e_go       = 1'b1;
            end else if (!enable) begin
                m_active = 1'b0;
            end
        end
        e_busy = m_active && (m_in_run || (n + 1) < m_gap_end);
    endtask

    task automatic emu_randomize();
        int r;
        emu_low      = $urandom_range(1, 5);
        emu_high     = emu_low + $urandom_range(1, 60);
        r            = $urandom_range(0, 7);
        emu_stuck_hi = (r == 0);
        emu_stuck_lo = (r == 1);
        emu_digit    = 4'($urandom_range(0, 15));
    endtask

    // Apply inputs for the current cycle, advance one clock, compare against the model.
    task automatic run_cycle(input logic dr);
        data_ready  = dr;
        lenet_ready = 1'b1;
        if (!emu_stuck_hi && cyc >= emu_go_at + emu_low &&
            (emu_stuck_lo || cyc < emu_go_at + emu_high)) begin
            lenet_ready = 1'b0;
        end
        lenet_digit = emu_digit;
        model_step();
        @(negedge clk);
        cyc++;
        chk("cycle",
            {19'd0, lenet_go, digit_valid, busy, timeout_err, overrun, digit, infer_count},
            {19'd0, e_go, e_dv, e_busy, e_to, e_ovr, e_digit, CW'(e_cnt)});
        if (lenet_go) begin
            go_cnt++;
            go_cyc    = cyc;
            emu_go_at = cyc;
            if (emu_rand) emu_randomize();
        end
        if (digit_valid) begin
            dv_cnt++;
            dv_cyc = cyc;
        end
        if (timeout_err && to_cyc < 0) to_cyc = cyc;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        data_ready = 1'b0;
        @(negedge clk);
        cyc++;
        chk("rst_go", 32'(lenet_go), 32'd0);
        chk("rst_digit", 32'(digit), 32'd0);
        chk("rst_dv", 32'(digit_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_count", 32'(infer_count), 32'd0);
        rst          = 1'b0;
        emu_go_at    = -1000;
        emu_stuck_hi = 1'b0;
        emu_stuck_lo = 1'b0;
        to_cyc       = -1;
        model_reset();
    endtask

    task automatic wait_free(input int lim);
        int k;
        k = 0;
        while (busy && k < lim) begin
            run_cycle(1'b0);
            k++;
        end
        chk("free_wait", 32'(busy), 32'd0);
    endtask

    task automatic wait_dv(input int lim);
        int d0;
        int k;
        d0 = dv_cnt;
        k  = 0;
        while (dv_cnt == d0 && k < lim) begin
            run_cycle(1'b0);
            k++;
        end
        chk("dv_wait", 32'(dv_cnt - d0), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulse_cyc;
        int g0;
        int d0;
        int k;
        logic [3:0]    dig_before;
        logic [CW-1:0] cnt_before;

        rst         = 1'b1;
        enable      = 1'b0;
        data_ready  = 1'b0;
        lenet_ready = 1'b1;
        lenet_digit = 4'd0;
        model_reset();

        // Reset values, then a single nominal inference returning 7.
        do_reset();
        enable    = 1'b1;
        emu_low   = 3;
        emu_high  = 50;
        emu_digit = 4'd7;
        run_cycle(1'b0);
        pulse_cyc = cyc;
        run_cycle(1'b1);
        chk("go_latency", 32'(go_cyc - pulse_cyc), 32'd1);
        d0 = dv_cnt;
        wait_dv(200);
        chk("done_latency", 32'(dv_cyc - go_cyc), 32'd51);
        chk("digit_7", 32'(digit), 32'd7);
        chk("count_1", 32'(infer_count), 32'd1);
        for (int i = 0; i < 5; i++) run_cycle(1'b0);
        chk("dv_single", 32'(dv_cnt - d0), 32'd1);

        // Two frames while the core is busy: overrun, then exactly one follow-up go after the gap.
        wait_free(40);
        run_cycle(1'b1);
        for (int i = 0; i < 10; i++) run_cycle(1'b0);
        run_cycle(1'b1);
        run_cycle(1'b0);
        run_cycle(1'b1);
        chk("overrun_set", 32'(overrun), 32'd1);
        wait_dv(200);
        g0 = go_cnt;
        k  = 0;
        while (go_cnt == g0 && k < 100) begin
            run_cycle(1'b0);
            k++;
        end
        chk("rerun_latency", 32'(go_cyc - dv_cyc), 32'd17);
        for (int i = 0; i < 120; i++) run_cycle(1'b0);
        chk("one_rerun", 32'(go_cnt - g0), 32'd1);

        // Core never drops ready: watchdog fires 100 cycles after go, result untouched.
        wait_free(40);
        emu_stuck_hi = 1'b1;
        dig_before   = digit;
        cnt_before   = infer_count;
        run_cycle(1'b1);
        k = 0;
        while (to_cyc < 0 && k < 200) begin
            run_cycle(1'b0);
            k++;
        end
        chk("timeout_latency", 32'(to_cyc - go_cyc), 32'd100);
        chk("timeout_count", 32'(infer_count), 32'(cnt_before));
        chk("timeout_digit", 32'(digit), 32'(dig_before));
        for (int i = 0; i < 15; i++) run_cycle(1'b0);
        chk("timeout_gap", 32'(busy), 32'd1);
        run_cycle(1'b0);
        chk("timeout_rearm", 32'(busy), 32'd0);
        emu_stuck_hi = 1'b0;

        // Enable drops mid-run: run finishes, gap runs, then frames are ignored.
        emu_digit = 4'd5;
        run_cycle(1'b1);
        for (int i = 0; i < 10; i++) run_cycle(1'b0);
        enable = 1'b0;
        wait_dv(200);
        chk("drain_digit", 32'(digit), 32'd5);
        for (int i = 0; i < 20; i++) run_cycle(1'b0);
        chk("drain_idle", 32'(busy), 32'd0);
        g0 = go_cnt;
        for (int i = 0; i < 40; i++) run_cycle((i % 7) == 3);
        enable = 1'b1;
        for (int i = 0; i < 30; i++) run_cycle(1'b0);
        chk("ignored_frames", 32'(go_cnt - g0), 32'd0);

        // Reset while waiting for the core to start: run abandoned silently.
        emu_low = 5;
        run_cycle(1'b1);
        run_cycle(1'b0);
        do_reset();
        g0 = go_cnt;
        d0 = dv_cnt;
        for (int i = 0; i < 60; i++) run_cycle(1'b0);
        chk("abandon_go", 32'(go_cnt - g0), 32'd0);
        chk("abandon_dv", 32'(dv_cnt - d0), 32'd0);

        // Seventeen short runs wrap the 4-bit counter to 1.
        emu_low  = 1;
        emu_high = 3;
        for (int i = 0; i < 17; i++) begin
            wait_free(40);
            emu_digit = 4'(i);
            run_cycle(1'b1);
            wait_dv(100);
        end
        chk("count_wrap", 32'(infer_count), 32'd1);

        // Random traffic against the model.
        do_reset();
        emu_rand = 1'b1;
        emu_randomize();
        enable = 1'b1;
        g0 = go_cnt;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            run_cycle($urandom_range(0, 24) == 0);
        end
        chk("random_activity", 32'(go_cnt > g0 + 10), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
